// File: rtl/note_select_ctrl.sv
// Note selection and play/stop control for the tone generator. It takes debounced
// button pulses and drives a registered half-period count and tone enable.
module note_select_ctrl #(
  parameter int OCT_MAX    = 3,
  parameter int GAP_CYCLES = 500000,
  parameter int GAP_W      = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_p,
  input  logic        down_p,
  input  logic        play_p,
  output logic [3:0]  note_idx,
  output logic [2:0]  octave,
  output logic [17:0] half_period,
  output logic        tone_en
);

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [2:0]       OCT_TOP  = 3'(OCT_MAX);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, cnt_nxt;
  logic [3:0]       note_nxt;
  logic [2:0]       oct_nxt;
  logic [17:0]      hp_nxt;
  logic             step_up, step_dn, step;

  // Octave-0 half periods (C4..B4); higher octaves halve by shifting.
  function automatic logic [17:0] base_hp(input logic [3:0] idx);
    case (idx)
      4'd0:    base_hp = 18'd191110;
      4'd1:    base_hp = 18'd180388;
      4'd2:    base_hp = 18'd170265;
      4'd3:    base_hp = 18'd160705;
      4'd4:    base_hp = 18'd151685;
      4'd5:    base_hp = 18'd143172;
      4'd6:    base_hp = 18'd135139;
      4'd7:    base_hp = 18'd127551;
      4'd8:    base_hp = 18'd120395;
      4'd9:    base_hp = 18'd113636;
      4'd10:   base_hp = 18'd107259;
      default: base_hp = 18'd101239;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = gap_cnt;
    note_nxt  = note_idx;
    oct_nxt   = octave;

    // Saturated steps at either end of the range count as no step at all.
    step_up = up_p & ~down_p & ~play_p & ~((note_idx == 4'd11) && (octave == OCT_TOP));
    step_dn = down_p & ~up_p & ~play_p & ~((note_idx == 4'd0) && (octave == 3'd0));
    step    = step_up | step_dn;

    if (step_up) begin
      if (note_idx == 4'd11) begin
        note_nxt = 4'd0;
        oct_nxt  = octave + 3'd1;
      end else begin
        note_nxt = note_idx + 4'd1;
      end
    end else if (step_dn) begin
      if (note_idx == 4'd0) begin
        note_nxt = 4'd11;
        oct_nxt  = octave - 3'd1;
      end else begin
        note_nxt = note_idx - 4'd1;
      end
    end

    case (state)
      STOP: begin
        if (play_p) state_nxt = PLAY;
      end
      PLAY: begin
        if (play_p) begin
          state_nxt = STOP;
        end else if (step && (GAP_CYCLES > 0)) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (play_p) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else if (step) begin
          cnt_nxt = GAP_LOAD;
        end else if (gap_cnt == '0) begin
          state_nxt = PLAY;
        end else begin
          cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = STOP;
        cnt_nxt   = '0;
      end
    endcase

    hp_nxt = base_hp(note_nxt) >> oct_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STOP;
      gap_cnt     <= '0;
      note_idx    <= 4'd9;
      octave      <= 3'd0;
      half_period <= 18'd113636;
      tone_en     <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= cnt_nxt;
      note_idx    <= note_nxt;
      octave      <= oct_nxt;
      half_period <= hp_nxt;
      tone_en     <= (state_nxt == PLAY);
    end
  end

endmodule

// File: tb/tb_note_select_ctrl.sv
// Checks note_select_ctrl against a linear-pitch reference model using directed
// corner cases followed by random button traffic.
module tb_note_select_ctrl;

  localparam int OCT_MAX = 3;
  localparam int GAP     = 4;
  localparam int POS_MAX = (OCT_MAX + 1) * 12 - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        up_p = 1'b0;
  logic        down_p = 1'b0;
  logic        play_p = 1'b0;
  logic [3:0]  note_idx;
  logic [2:0]  octave;
  logic [17:0] half_period;
  logic        tone_en;

  int vectors = 0;
  int miscompares = 0;

  // Pitch position counted in semitones above C of octave 0.
  int pos = 9;
  bit playing = 1'b0;
  int gap_left = 0;

  int base [12] = '{191110, 180388, 170265, 160705, 151685, 143172,
                    135139, 127551, 120395, 113636, 107259, 101239};

  note_select_ctrl #(
    .OCT_MAX   (OCT_MAX),
    .GAP_CYCLES(GAP),
    .GAP_W     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_p       (up_p),
    .down_p     (down_p),
    .play_p     (play_p),
    .note_idx   (note_idx),
    .octave     (octave),
    .half_period(half_period),
    .tone_en    (tone_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit u, input bit d, input bit p);
    bit vu, vd;
    rst = r; up_p = u; down_p = d; play_p = p;
    @(posedge clk);
    if (r) begin
      pos = 9; playing = 1'b0; gap_left = 0;
    end else if (p) begin
      playing = !playing; gap_left = 0;
    end else begin
      vu = u && !d && (pos < POS_MAX);
      vd = d && !u && (pos > 0);
      if (vu) pos++;
      if (vd) pos--;
      if ((vu || vd) && playing && GAP > 0) gap_left = GAP;
      else if (gap_left > 0) gap_left--;
    end
    #1;
    check("note_idx", 32'(note_idx), pos % 12);
    check("octave", 32'(octave), pos / 12);
    check("half_period", 32'(half_period), base[pos % 12] >> (pos / 12));
    check("tone_en", 32'(tone_en), (playing && gap_left == 0) ? 1 : 0);
  endtask

  initial begin
    // Reset
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    check("rst_note", 32'(note_idx), 9);
    check("rst_oct", 32'(octave), 0);
    check("rst_hp", 32'(half_period), 113636);
    check("rst_tone", 32'(tone_en), 0);

    // Wrap upward into octave 1, then saturate at the top
    repeat (3) apply(0, 1, 0, 0);
    check("wrap_note", 32'(note_idx), 0);
    check("wrap_oct", 32'(octave), 1);
    check("wrap_hp", 32'(half_period), 95555);
    repeat (35) apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    check("sat_note", 32'(note_idx), 11);
    check("sat_oct", 32'(octave), 3);
    check("sat_hp", 32'(half_period), 12654);

    // Saturate at the bottom
    apply(1, 0, 0, 0);
    repeat (10) apply(0, 0, 1, 0);
    check("floor_note", 32'(note_idx), 0);
    check("floor_hp", 32'(half_period), 191110);

    // Gap after a step while playing
    apply(1, 0, 0, 0);
    apply(0, 0, 0, 1);
    check("play_tone", 32'(tone_en), 1);
    apply(0, 1, 0, 0);
    check("gap_hp", 32'(half_period), 107259);
    check("gap_tone0", 32'(tone_en), 0);
    repeat (3) apply(0, 0, 0, 0);
    check("gap_tone3", 32'(tone_en), 0);
    apply(0, 0, 0, 0);
    check("gap_end", 32'(tone_en), 1);

    // Restart mid-gap, then stop from the gap
    apply(0, 1, 0, 0);
    repeat (2) apply(0, 0, 0, 0);
    apply(0, 1, 0, 0);
    repeat (3) apply(0, 0, 0, 0);
    check("restart_tone", 32'(tone_en), 0);
    apply(0, 0, 0, 0);
    check("restart_end", 32'(tone_en), 1);
    apply(0, 0, 1, 0);
    apply(0, 0, 0, 1);
    repeat (6) apply(0, 0, 0, 0);
    check("stop_tone", 32'(tone_en), 0);

    // Simultaneous pulses
    apply(0, 1, 1, 0);
    apply(0, 1, 0, 1);
    check("play_up_tone", 32'(tone_en), 1);
    apply(0, 0, 1, 0);
    apply(1, 0, 0, 0);
    check("rst_gap_note", 32'(note_idx), 9);
    check("rst_gap_tone", 32'(tone_en), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
